// File: rtl/pc_step_ctrl_pkg.sv
// Shared encodings for the multi-cycle PC/fetch sequencer.
// State codes are plain 3-bit constants so that legacy code can compare them directly.
package pc_step_ctrl_pkg;

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;
  localparam logic [2:0] S_HLT = 3'd5;
  localparam logic [2:0] S_FLT = 3'd6;

  // Select code for the next-PC helper.
  typedef enum logic [1:0] {
    PC_NEXT = 2'd0,   // PC + instruction size
    PC_REL  = 2'd1,   // PC-relative branch target
    PC_ABS  = 2'd2,   // absolute jump target
    PC_HALT = 2'd3    // hold PC
  } pc_sel_e;

endpackage

// File: rtl/pc_step_ctrl_if.sv
// Control bundle between the step sequencer and the fetch/decode/memory datapath.
// master = sequencer side, slave = datapath/memory side.
interface pc_step_ctrl_if #(
  parameter int CNT_W = 32
);

  // memory acknowledges
  logic             imem_ack;
  logic             dmem_ack;
  // decoded instruction fields
  logic             is_jump;
  logic             is_branch;
  logic             branch_taken;
  logic             is_mem;
  logic             is_load;
  logic             is_halt;
  // sequencer controls
  logic             imem_req;
  logic             ir_we;
  logic             dmem_req;
  logic             reg_we;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] instret;

  modport master (
    input  imem_ack, dmem_ack, is_jump, is_branch, branch_taken, is_mem, is_load, is_halt,
    output imem_req, ir_we, dmem_req, reg_we, pc_we, pc_sel, halted, fault, instret
  );

  modport slave (
    output imem_ack, dmem_ack, is_jump, is_branch, branch_taken, is_mem, is_load, is_halt,
    input  imem_req, ir_we, dmem_req, reg_we, pc_we, pc_sel, halted, fault, instret
  );

endinterface

// File: rtl/pc_step_ctrl_req_watchdog.sv
// Request watchdog: counts consecutive request-without-ack cycles and flags
// expiry in the cycle that would be the ACK_TIMEOUT-th unanswered one.
// ACK_TIMEOUT = 0 disables expiry entirely.
module pc_step_ctrl_req_watchdog #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic RST,
  input  logic i_clear,   // state is changing: restart the count
  input  logic i_tick,    // request outstanding and no ack this cycle
  output logic o_expire   // this unanswered cycle is the last one allowed
);

  localparam int              TW      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0]   LAST    = TW'((ACK_TIMEOUT > 0) ? (ACK_TIMEOUT - 1) : 0);
  localparam bit              ENABLED = (ACK_TIMEOUT > 0);

  logic [TW-1:0] r_count;

  // Count unanswered request cycles; any state change restarts from zero.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_tick) begin
      r_count <= r_count + TW'(1);
    end
  end

  // An ack in the final cycle drops i_tick, so it takes precedence over expiry.
  assign o_expire = ENABLED && i_tick && (r_count == LAST);

endmodule

// File: rtl/pc_step_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer: drives PC load/select, memory requests,
// register writes and the retired-instruction counter. HLT and FLT are sticky until RST.
module pc_step_ctrl
  import pc_step_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 RST,
  pc_step_ctrl_if.master       bus
);

  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic [CNT_W-1:0] r_instret;
  logic             w_retire;
  logic             w_tick;
  logic             w_clear;
  logic             w_expire;

  logic             w_imem_req;
  logic             w_ir_we;
  logic             w_dmem_req;
  logic             w_reg_we;
  logic             w_pc_we;
  pc_sel_e          w_pc_sel;
  logic             w_halted;
  logic             w_fault;

  // Only the two request states can stall on memory; acks elsewhere are ignored.
  assign w_tick  = ((r_state == S_IF)  && !bus.imem_ack) ||
                   ((r_state == S_MEM) && !bus.dmem_ack);
  assign w_clear = (w_state_next != r_state);

  pc_step_ctrl_req_watchdog #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_req_watchdog (
    .clk      (clk),
    .RST      (RST),
    .i_clear  (w_clear),
    .i_tick   (w_tick),
    .o_expire (w_expire)
  );

  // Next-state and output decode from the current state and this cycle's inputs.
  always_comb begin
    w_state_next = r_state;
    w_imem_req   = 1'b0;
    w_ir_we      = 1'b0;
    w_dmem_req   = 1'b0;
    w_reg_we     = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_sel     = PC_NEXT;
    w_halted     = 1'b0;
    w_fault      = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      S_IF: begin
        w_imem_req = 1'b1;
        if (bus.imem_ack) begin
          w_ir_we      = 1'b1;
          w_state_next = S_ID;
        end else if (w_expire) begin
          w_state_next = S_FLT;
        end
      end
      S_ID: begin
        if (bus.is_halt) begin
          w_retire     = 1'b1;
          w_state_next = S_HLT;
        end else if (bus.is_jump) begin
          w_pc_we      = 1'b1;
          w_pc_sel     = PC_ABS;
          w_retire     = 1'b1;
          w_state_next = S_IF;
        end else begin
          w_state_next = S_EXE;
        end
      end
      S_EXE: begin
        if (bus.is_branch) begin
          w_pc_we      = 1'b1;
          w_pc_sel     = bus.branch_taken ? PC_REL : PC_NEXT;
          w_retire     = 1'b1;
          w_state_next = S_IF;
        end else if (bus.is_mem) begin
          w_state_next = S_MEM;
        end else begin
          w_state_next = S_WB;
        end
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        if (bus.dmem_ack) begin
          if (bus.is_load) begin
            w_state_next = S_WB;
          end else begin
            // store completes here; nothing to write back
            w_pc_we      = 1'b1;
            w_retire     = 1'b1;
            w_state_next = S_IF;
          end
        end else if (w_expire) begin
          w_state_next = S_FLT;
        end
      end
      S_WB: begin
        w_reg_we     = 1'b1;
        w_pc_we      = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_IF;
      end
      S_HLT: begin
        w_pc_sel = PC_HALT;
        w_halted = 1'b1;
      end
      S_FLT: begin
        w_fault = 1'b1;
      end
      default: begin
        // unused encoding: restart fetch
        w_state_next = S_IF;
      end
    endcase
  end

  // State register; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign bus.imem_req = w_imem_req;
  assign bus.ir_we    = w_ir_we;
  assign bus.dmem_req = w_dmem_req;
  assign bus.reg_we   = w_reg_we;
  assign bus.pc_we    = w_pc_we;
  assign bus.pc_sel   = w_pc_sel;
  assign bus.halted   = w_halted;
  assign bus.fault    = w_fault;
  assign bus.instret  = r_instret;

endmodule

// File: tb/tb_pc_step_ctrl.sv
// Directed bench for pc_step_ctrl. Inputs change 1 time unit after a rising edge;
// combinational outputs are sampled 1 unit later, well away from the edge.
module tb_pc_step_ctrl;

  logic clk;
  logic RST;
  int   checks;
  int   errors;

  pc_step_ctrl_if #(.CNT_W(32)) bus ();

  pc_step_ctrl #(
    .ACK_TIMEOUT (15),
    .CNT_W       (32)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: {imem_req, ir_we, dmem_req, reg_we, pc_we, pc_sel[1:0], halted, fault}
  function automatic logic [8:0] outs();
    return {bus.imem_req, bus.ir_we, bus.dmem_req, bus.reg_we, bus.pc_we,
            bus.pc_sel, bus.halted, bus.fault};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  // settle inputs, then compare outputs and counter
  task automatic look(input string tag, input logic [8:0] exp_o, input logic [31:0] exp_cnt);
    #1;
    chk({tag, ".outs"}, {23'd0, outs()}, {23'd0, exp_o});
    chk({tag, ".instret"}, bus.instret, exp_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.imem_ack     = 1'b0;
    bus.dmem_ack     = 1'b0;
    bus.is_jump      = 1'b0;
    bus.is_branch    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.is_mem       = 1'b0;
    bus.is_load      = 1'b0;
    bus.is_halt      = 1'b0;
  endtask

  localparam logic [8:0] O_IF    = 9'b1_0_0_0_0_00_0_0;
  localparam logic [8:0] O_IFACK = 9'b1_1_0_0_0_00_0_0;
  localparam logic [8:0] O_NONE  = 9'b0_0_0_0_0_00_0_0;
  localparam logic [8:0] O_WB    = 9'b0_0_0_1_1_00_0_0;
  localparam logic [8:0] O_BRT   = 9'b0_0_0_0_1_01_0_0;
  localparam logic [8:0] O_BRN   = 9'b0_0_0_0_1_00_0_0;
  localparam logic [8:0] O_JMP   = 9'b0_0_0_0_1_10_0_0;
  localparam logic [8:0] O_MEM   = 9'b0_0_1_0_0_00_0_0;
  localparam logic [8:0] O_ST    = 9'b0_0_1_0_1_00_0_0;
  localparam logic [8:0] O_HLT   = 9'b0_0_0_0_0_11_1_0;
  localparam logic [8:0] O_FLT   = 9'b0_0_0_0_0_00_0_1;

  initial begin
    checks = 0;
    errors = 0;
    clr_in();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;

    // reset state: fetching, nothing else active
    look("reset", O_IF, 32'd0);

    // ALU op: ack in first IF cycle, 4 cycles total
    bus.imem_ack = 1'b1; look("alu.if", O_IFACK, 32'd0); tick();
    clr_in();            look("alu.id", O_NONE, 32'd0);  tick();
                         look("alu.exe", O_NONE, 32'd0); tick();
                         look("alu.wb", O_WB, 32'd0);    tick();
                         look("alu.done", O_IF, 32'd1);

    // taken branch
    bus.imem_ack = 1'b1; tick();
    clr_in(); bus.is_branch = 1'b1; look("brt.id", O_NONE, 32'd1); tick();
    bus.branch_taken = 1'b1;        look("brt.exe", O_BRT, 32'd1); tick();
    clr_in();                       look("brt.done", O_IF, 32'd2);

    // not-taken branch
    bus.imem_ack = 1'b1; tick();
    clr_in(); bus.is_branch = 1'b1; tick();
    look("brn.exe", O_BRN, 32'd2); tick();
    clr_in();                       look("brn.done", O_IF, 32'd3);

    // absolute jump, retires from ID
    bus.imem_ack = 1'b1; tick();
    clr_in(); bus.is_jump = 1'b1; look("jmp.id", O_JMP, 32'd3); tick();
    clr_in();                     look("jmp.done", O_IF, 32'd4);

    // stray dmem_ack while fetching is ignored
    bus.dmem_ack = 1'b1; tick();
    clr_in(); look("stray.dack", O_IF, 32'd4);

    // load with three wait states: 8 cycles overall
    bus.imem_ack = 1'b1; tick();
    clr_in(); bus.is_mem = 1'b1; bus.is_load = 1'b1; tick();
    look("ld.exe", O_NONE, 32'd4); tick();
    look("ld.mem0", O_MEM, 32'd4); tick();
    look("ld.mem1", O_MEM, 32'd4); tick();
    look("ld.mem2", O_MEM, 32'd4); tick();
    bus.dmem_ack = 1'b1; look("ld.mem3", O_MEM, 32'd4); tick();
    clr_in();            look("ld.wb", O_WB, 32'd4);    tick();
                         look("ld.done", O_IF, 32'd5);

    // store with same-cycle ack retires from MEM
    bus.imem_ack = 1'b1; tick();
    clr_in(); bus.is_mem = 1'b1; tick();
    tick();
    bus.dmem_ack = 1'b1; look("st.mem", O_ST, 32'd5); tick();
    clr_in();            look("st.done", O_IF, 32'd6);

    // ack arriving in the 15th unanswered-window cycle wins over the watchdog
    for (int i = 0; i < 14; i++) tick();
    bus.imem_ack = 1'b1; look("late.ack", O_IFACK, 32'd6); tick();
    clr_in();            look("late.id", O_NONE, 32'd6);   tick();
    tick();
    tick();
    look("late.done", O_IF, 32'd7);

    // no ack at all: fault after 15 IF cycles
    for (int i = 0; i < 14; i++) tick();
    look("to.last", O_IF, 32'd7); tick();
    look("to.fault", O_FLT, 32'd7);
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1; tick(); tick();
    look("to.sticky", O_FLT, 32'd7);
    clr_in();

    // reset leaves fault
    RST = 1'b1; tick();
    RST = 1'b0; look("flt.rst", O_IF, 32'd0);

    // halt (with jump also set: halt has priority)
    bus.imem_ack = 1'b1; tick();
    clr_in(); bus.is_halt = 1'b1; bus.is_jump = 1'b1; look("hlt.id", O_NONE, 32'd0); tick();
    clr_in(); look("hlt.state", O_HLT, 32'd1);
    bus.imem_ack = 1'b1; tick(); tick();
    look("hlt.sticky", O_HLT, 32'd1);
    clr_in();

    // reset while waiting in MEM drops the data request
    RST = 1'b1; tick();
    RST = 1'b0;
    bus.imem_ack = 1'b1; tick();
    clr_in(); bus.is_mem = 1'b1; bus.is_load = 1'b1; tick();
    tick();
    look("rstm.mem", O_MEM, 32'd0);
    RST = 1'b1; tick();
    RST = 1'b0; clr_in();
    look("rstm.if", O_IF, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
